lvl_queue_server: RTL and testbench
===================================

// Module: lvl_queue_server
// PURPOSE
//  Owns the elevator level queue and services it (consumer end of the request path).
//  Accepts accepted levels from add_new_lvl_logic and exports queue/tail back to it.
//  Moves the car toward the head entry one level per travel period, then holds the door open.
//  Pops the head entry when the door period ends. One clock domain.
// PARAMETERS
//  LVL_W          2   bits per level code (4 levels, 0..3)
//  DEPTH          4   queue entries; queue bus is DEPTH*LVL_W = 8 bits
//  TRAVEL_CYCLES  8   cycles per one-level move (>=1)
//  DOOR_CYCLES    16  cycles door held open before pop (>=1)
// PORTS
//  clk          in   1  clock, rising edge
//  rst          in   1  asynchronous reset, active-high
//  add_en       in   1  push request (driven by add_new_lvl)
//  add_lvl      in   2  level to push, sampled when add_en=1
//  queue        out  8  packed entries; entry i = queue[2i+1:2i]; entry 0 = head
//  tail         out  3  valid-entry count, 0..4; entries >= tail are don't-care (driven 0)
//  cur_lvl      out  2  current car level
//  moving_up    out  1  MOVE state and head > cur_lvl
//  moving_down  out  1  MOVE state and head < cur_lvl
//  door_open    out  1  DOOR state
//  served       out  1  1-cycle pulse on pop
//  served_lvl   out  2  level popped; valid with served, else 0
//  drop_err     out  1  1-cycle pulse: push attempted with tail==4 and no pop that cycle
// BEHAVIOUR
//  Reset (async): queue=0, tail=0, cur_lvl=0, state=IDLE, timer=0, all flags/pulses 0.
//  States: IDLE, MOVE, DOOR (2-bit encoding).
//  IDLE: tail==0 -> stay. tail!=0 and head==cur_lvl -> DOOR, timer=DOOR_CYCLES-1.
//    tail!=0 and head!=cur_lvl -> MOVE, timer=TRAVEL_CYCLES-1.
//  MOVE: timer!=0 -> timer-1. timer==0 -> cur_lvl +/-1 toward head.
//    If the new cur_lvl==head -> DOOR, timer=DOOR_CYCLES-1. Else reload TRAVEL_CYCLES-1.
//  DOOR: timer!=0 -> timer-1. timer==0 -> pop, served=1, served_lvl=head, -> IDLE.
//  Pop: entries shift down one (entry i <= entry i+1), top entry <= 0, tail-1.
//  Push (add_en=1):
//    - no pop and tail<4: entry[tail]<=add_lvl, tail+1.
//    - with pop the same cycle: write at tail-1 after the shift; tail unchanged.
//    - tail==4 and no pop: ignored, drop_err=1.
//  Head stays stable except on pop, so no target latch is needed.
//  Duplicate levels: no dedupe here; add_new_lvl_logic filters them.
//  IDLE with head==cur_lvl enters DOOR in 1 cycle.
//  Level change: cur_lvl updates TRAVEL_CYCLES cycles after MOVE entry.
//  All outputs are registered or decoded from registers only; no combinational path from add_en.
//  Reset mid-MOVE/DOOR: immediate return to reset values; pending entries lost.
// STRUCTURE
//  elevator_pkg: LVL_W, DEPTH, state encodings IDLE/MOVE/DOOR, level type width.
//  Sub-module lvl_timer: loadable down-counter (load, load_val, dec, zero).
//    Shared by travel and door periods.
//  Top: queue shift register, tail counter, FSM, direction decode.
// TESTING
//  1 Reset asserted mid-MOVE (cur_lvl=1, tail=2).
//    -> same cycle async: tail=0, queue=0, cur_lvl=0, all flags 0.
//  2 From cur_lvl=0, push lvl 2:
//    -> moving_up 16 cycles; cur_lvl=1 @+8, 2 @+16.
//    -> door_open 16 cycles; served=1, served_lvl=2; tail back to 0.
//  3 cur_lvl=0, push lvl 0.
//    -> DOOR the cycle after IDLE sees tail=1, no movement; served_lvl=0 after 16 cycles.
//  4 Push 1,2,3,0 then a 5th push (3) with no pop.
//    -> tail=4, queue=8'b00_11_10_01, drop_err pulse, queue unchanged.
//  5 tail=4, push lvl 1 in the pop cycle.
//    -> tail stays 4, queue shifts and entry3=1, served pulse, no drop_err.
//  6 At cur_lvl=3, push lvl 0.
//    -> moving_down 24 cycles through 2,1,0; moving_up never set.

Source files
------------

// File: rtl/lvl_queue_server_pkg.sv
// Shared types and sizing for the elevator level queue server.
package lvl_queue_server_pkg;

  localparam int unsigned LVL_W   = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned QUEUE_W = DEPTH * LVL_W;
  localparam int unsigned TAIL_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W   = $clog2(DEPTH);

  typedef logic [LVL_W-1:0]  lvl_t;
  typedef logic [TAIL_W-1:0] tail_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lvl_queue_server_if.sv
// Request path between add_new_lvl_logic (master) and the queue server (slave).
interface lvl_queue_server_if;
  import lvl_queue_server_pkg::*;

  logic               add_en;
  lvl_t               add_lvl;
  logic [QUEUE_W-1:0] queue;
  tail_t              tail;

  modport master (output add_en, add_lvl, input queue, tail);
  modport slave  (input add_en, add_lvl, output queue, tail);

endinterface

// File: rtl/lvl_queue_server_lvl_timer.sv
// Loadable down-counter shared by the travel and door periods.
module lvl_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (dec && (count_q != '0))
      count_d = count_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/lvl_queue_server.sv
// Elevator level queue owner: stores pushed levels, drives the car to the head
// entry one level per travel period, holds the door, then pops the head.
module lvl_queue_server
  import lvl_queue_server_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  lvl_queue_server_if.slave     qif,
  output lvl_t                  cur_lvl,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic                  served,
  output lvl_t                  served_lvl,
  output logic                  drop_err
);

  localparam int unsigned TMR_W = $clog2(max_u(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
  localparam logic [TMR_W-1:0] TRAVEL_RELOAD = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0] DOOR_RELOAD   = TMR_W'(DOOR_CYCLES - 1);

  state_e                      state_q, state_d;
  logic [DEPTH-1:0][LVL_W-1:0] queue_q, queue_d;
  tail_t                       tail_q, tail_d;
  lvl_t                        cur_lvl_q, cur_lvl_d;
  logic                        served_q, served_d;
  lvl_t                        served_lvl_q, served_lvl_d;
  logic                        drop_err_q, drop_err_d;

  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  lvl_t             head, next_lvl;
  logic             pop;

  assign head = queue_q[0];
  assign pop  = (state_q == ST_DOOR) && tmr_zero;

  lvl_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Queue and tail: a push in the pop cycle lands in the slot freed by the shift.
  always_comb begin
    queue_d      = queue_q;
    tail_d       = tail_q;
    served_d     = 1'b0;
    served_lvl_d = '0;
    drop_err_d   = 1'b0;
    if (pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++)
        queue_d[i] = queue_q[i+1];
      queue_d[DEPTH-1] = '0;
      served_d         = 1'b1;
      served_lvl_d     = head;
    end
    if (qif.add_en) begin
      if (pop)
        queue_d[idx_t'(tail_q - tail_t'(1))] = qif.add_lvl;
      else if (tail_q != tail_t'(DEPTH)) begin
        queue_d[idx_t'(tail_q)] = qif.add_lvl;
        tail_d                  = tail_q + tail_t'(1);
      end else
        drop_err_d = 1'b1;
    end else if (pop)
      tail_d = tail_q - tail_t'(1);
  end

  always_comb begin
    state_d   = state_q;
    cur_lvl_d = cur_lvl_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;
    next_lvl  = (head > cur_lvl_q) ? cur_lvl_q + lvl_t'(1) : cur_lvl_q - lvl_t'(1);
    case (state_q)
      ST_IDLE: begin
        if (tail_q != '0) begin
          tmr_load = 1'b1;
          if (head == cur_lvl_q) begin
            state_d = ST_DOOR;
            tmr_val = DOOR_RELOAD;
          end else begin
            state_d = ST_MOVE;
            tmr_val = TRAVEL_RELOAD;
          end
        end
      end
      ST_MOVE: begin
        if (!tmr_zero)
          tmr_dec = 1'b1;
        else begin
          cur_lvl_d = next_lvl;
          tmr_load  = 1'b1;
          if (next_lvl == head) begin
            state_d = ST_DOOR;
            tmr_val = DOOR_RELOAD;
          end else
            tmr_val = TRAVEL_RELOAD;
        end
      end
      ST_DOOR: begin
        if (!tmr_zero) tmr_dec = 1'b1;
        else           state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      queue_q      <= '0;
      tail_q       <= '0;
      cur_lvl_q    <= '0;
      served_q     <= 1'b0;
      served_lvl_q <= '0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      queue_q      <= queue_d;
      tail_q       <= tail_d;
      cur_lvl_q    <= cur_lvl_d;
      served_q     <= served_d;
      served_lvl_q <= served_lvl_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign qif.queue   = queue_q;
  assign qif.tail    = tail_q;
  assign cur_lvl     = cur_lvl_q;
  assign moving_up   = (state_q == ST_MOVE) && (head > cur_lvl_q);
  assign moving_down = (state_q == ST_MOVE) && (head < cur_lvl_q);
  assign door_open   = (state_q == ST_DOOR);
  assign served      = served_q;
  assign served_lvl  = served_lvl_q;
  assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_lvl_queue_server.sv
// Directed bench for lvl_queue_server: travel, door, queue full/drop, push-on-pop, reset.
module tb_lvl_queue_server;
  import lvl_queue_server_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  lvl_t cur_lvl, served_lvl;
  logic moving_up, moving_down, door_open, served, drop_err;
  int   checks = 0;
  int   errors = 0;

  lvl_queue_server_if qif();

  lvl_queue_server #(.TRAVEL_CYCLES(8), .DOOR_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .qif         (qif),
    .cur_lvl     (cur_lvl),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .door_open   (door_open),
    .served      (served),
    .served_lvl  (served_lvl),
    .drop_err    (drop_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    qif.add_en  = 1'b0;
    qif.add_lvl = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input lvl_t l);
    qif.add_en  = 1'b1;
    qif.add_lvl = l;
    step();
    qif.add_en  = 1'b0;
    qif.add_lvl = '0;
  endtask

  task automatic check_idle_zero(input string tag);
    checks++;
    if ({qif.tail, qif.queue, cur_lvl, moving_up, moving_down, door_open, served, served_lvl, drop_err} !== 20'h0) begin
      errors++;
      $display("FAIL %s: tail=%0d queue=%h cur=%0d up=%b dn=%b door=%b srv=%b srvl=%0d drop=%b, all required 0",
               tag, qif.tail, qif.queue, cur_lvl, moving_up, moving_down, door_open, served, served_lvl, drop_err);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_zero("reset_state");
  endtask

  task automatic test_move_up();
    do_reset();
    push(2'd2);
    checks++;
    if (qif.tail !== 3'd1 || moving_up !== 1'b0) begin
      errors++;
      $display("FAIL up_idle: tail=%0d up=%b, required 1/0", qif.tail, moving_up);
    end
    step();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (moving_up !== 1'b1 || moving_down !== 1'b0 || cur_lvl !== lvl_t'(k / 8)) begin
        errors++;
        $display("FAIL up_move[%0d]: up=%b dn=%b cur=%0d, required 1/0/%0d", k, moving_up, moving_down, cur_lvl, k / 8);
      end
      step();
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (door_open !== 1'b1 || moving_up !== 1'b0 || cur_lvl !== 2'd2 || served !== 1'b0) begin
        errors++;
        $display("FAIL up_door[%0d]: door=%b up=%b cur=%0d srv=%b, required 1/0/2/0", k, door_open, moving_up, cur_lvl, served);
      end
      step();
    end
    checks++;
    if (served !== 1'b1 || served_lvl !== 2'd2 || qif.tail !== 3'd0 || door_open !== 1'b0) begin
      errors++;
      $display("FAIL up_served: srv=%b srvl=%0d tail=%0d door=%b, required 1/2/0/0", served, served_lvl, qif.tail, door_open);
    end
    step();
    checks++;
    if (served !== 1'b0 || served_lvl !== 2'd0) begin
      errors++;
      $display("FAIL up_pulse: srv=%b srvl=%0d, required 0/0", served, served_lvl);
    end
  endtask

  task automatic test_same_level();
    do_reset();
    push(2'd0);
    checks++;
    if (door_open !== 1'b0 || qif.tail !== 3'd1) begin
      errors++;
      $display("FAIL same_idle: door=%b tail=%0d, required 0/1", door_open, qif.tail);
    end
    step();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (door_open !== 1'b1 || moving_up !== 1'b0 || moving_down !== 1'b0 || cur_lvl !== 2'd0) begin
        errors++;
        $display("FAIL same_door[%0d]: door=%b up=%b dn=%b cur=%0d, required 1/0/0/0", k, door_open, moving_up, moving_down, cur_lvl);
      end
      step();
    end
    checks++;
    if (served !== 1'b1 || served_lvl !== 2'd0 || qif.tail !== 3'd0) begin
      errors++;
      $display("FAIL same_served: srv=%b srvl=%0d tail=%0d, required 1/0/0", served, served_lvl, qif.tail);
    end
  endtask

  task automatic test_full_drop();
    do_reset();
    push(2'd1);
    push(2'd2);
    push(2'd3);
    push(2'd0);
    checks++;
    if (qif.tail !== 3'd4 || qif.queue !== 8'b00_11_10_01 || drop_err !== 1'b0) begin
      errors++;
      $display("FAIL full_fill: tail=%0d queue=%b drop=%b, required 4/00111001/0", qif.tail, qif.queue, drop_err);
    end
    push(2'd3);
    checks++;
    if (drop_err !== 1'b1 || qif.tail !== 3'd4 || qif.queue !== 8'b00_11_10_01) begin
      errors++;
      $display("FAIL full_drop: drop=%b tail=%0d queue=%b, required 1/4/00111001", drop_err, qif.tail, qif.queue);
    end
    step();
    checks++;
    if (drop_err !== 1'b0) begin
      errors++;
      $display("FAIL full_drop_pulse: drop=%b, required 0", drop_err);
    end
  endtask

  task automatic test_push_on_pop();
    int  n = 0;
    logic seen = 1'b0;
    while (!seen && n < 200) begin
      if (door_open === 1'b1) seen = 1'b1;
      else begin
        step();
        n++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL pop_wait_door: door_open=%b after %0d cycles, required 1", door_open, n);
    end else begin
      for (int k = 0; k < 15; k++) step();
      push(2'd1);
      checks++;
      if (served !== 1'b1 || served_lvl !== 2'd1 || qif.tail !== 3'd4 ||
          qif.queue !== 8'b01_00_11_10 || drop_err !== 1'b0) begin
        errors++;
        $display("FAIL pop_push: srv=%b srvl=%0d tail=%0d queue=%b drop=%b, required 1/1/4/01001110/0",
                 served, served_lvl, qif.tail, qif.queue, drop_err);
      end
    end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    push(2'd2);
    push(2'd3);
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (cur_lvl !== 2'd1 || qif.tail !== 3'd2 || moving_up !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: cur=%0d tail=%0d up=%b, required 1/2/1", cur_lvl, qif.tail, moving_up);
    end
    #1 rst = 1'b1;
    #1;
    check_idle_zero("reset_mid_move");
    step();
    rst = 1'b0;
  endtask

  task automatic test_move_down();
    int n = 0;
    do_reset();
    push(2'd3);
    while (served !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (served !== 1'b1 || cur_lvl !== 2'd3) begin
      errors++;
      $display("FAIL down_reach3: srv=%b cur=%0d after %0d cycles, required 1/3", served, cur_lvl, n);
    end
    push(2'd0);
    step();
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (moving_down !== 1'b1 || moving_up !== 1'b0 || cur_lvl !== lvl_t'(3 - k / 8)) begin
        errors++;
        $display("FAIL down_move[%0d]: dn=%b up=%b cur=%0d, required 1/0/%0d", k, moving_down, moving_up, cur_lvl, 3 - k / 8);
      end
      step();
    end
    checks++;
    if (door_open !== 1'b1 || moving_down !== 1'b0 || cur_lvl !== 2'd0) begin
      errors++;
      $display("FAIL down_arrive: door=%b dn=%b cur=%0d, required 1/0/0", door_open, moving_down, cur_lvl);
    end
  endtask

  initial begin
    qif.add_en  = 1'b0;
    qif.add_lvl = '0;
    test_reset();
    test_move_up();
    test_same_level();
    test_full_drop();
    test_push_on_pop();
    test_reset_mid_move();
    test_move_down();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
